// File: rtl/score_text_renderer.sv
// score_text_renderer: converts the binary score to four decimal glyphs drawn on the VGA stream
module score_text_renderer #(
  parameter int X0         = 480,
  parameter int Y0         = 64,
  parameter int DIGITS     = 4,
  parameter int SCALE_LOG2 = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] score_in,
  input  logic        score_load,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  output logic [3:0]  char_code,
  output logic [2:0]  char_row,
  input  logic [7:0]  glyph_bits,
  output logic        text_on,
  output logic        busy
);
  localparam logic [9:0] BOX_W = 10'(DIGITS * 8 << SCALE_LOG2);
  localparam logic [9:0] BOX_H = 10'(8 << SCALE_LOG2);
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t      state_q, state_d;
  logic [29:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [13:0] pend_val_q, pend_val_d;
  logic [15:0] disp_q, disp_d;
  logic        busy_q, busy_d;
  logic        text_on_q, text_on_d;
  logic [13:0] score_sat;
  logic [15:0] bcd_adj;
  logic [9:0]  rel_x, rel_y;
  logic        in_box;
  logic [1:0]  idx;
  logic [2:0]  col;
  logic [3:0]  code [4];
  // double-dabble sequencer: saturate, queue loads while busy, publish digits only when complete
  always_comb begin
    score_sat = score_in > 14'd9999 ? 14'd9999 : score_in;
    for (int i = 0; i < 4; i++)
      bcd_adj[i*4 +: 4] = shift_q[14+i*4 +: 4] >= 4'd5 ? shift_q[14+i*4 +: 4] + 4'd3 : shift_q[14+i*4 +: 4];
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    if (score_load && state_q != IDLE) begin
      pend_d     = 1'b1;
      pend_val_d = score_sat;
    end
    case (state_q)
      IDLE: if (score_load) begin
        state_d = CONVERT;
        shift_d = {16'd0, score_sat};
        cnt_d   = 4'd0;
      end
      CONVERT: begin
        shift_d = {bcd_adj[14:0], shift_q[13:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd13 ? DONE : CONVERT;
      end
      DONE: begin
        disp_d  = shift_q[29:14];
        pend_d  = 1'b0;
        state_d = score_load || pend_q ? CONVERT : IDLE;
        shift_d = {16'd0, score_load ? score_sat : pend_val_q};
        cnt_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // pixel addressing into the glyph ROM with leading-zero blanking
  always_comb begin
    rel_x     = pix_x - 10'(X0);
    rel_y     = pix_y - 10'(Y0);
    in_box    = rel_x < BOX_W && rel_y < BOX_H;
    idx       = 2'(rel_x >> (3 + SCALE_LOG2));
    col       = 3'(rel_x >> SCALE_LOG2);
    code[0]   = disp_q[15:12] == 4'd0 ? 4'd15 : disp_q[15:12];
    code[1]   = disp_q[15:8] == 8'd0 ? 4'd15 : disp_q[11:8];
    code[2]   = disp_q[15:4] == 12'd0 ? 4'd15 : disp_q[7:4];
    code[3]   = disp_q[3:0];
    char_code = in_box ? code[idx] : 4'd15;
    char_row  = in_box ? 3'(rel_y >> SCALE_LOG2) : 3'd0;
    text_on_d = video_on & in_box & glyph_bits[3'd7 - col];
  end
  // state registers; reset aborts any conversion and shows a lone zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      busy_q     <= 1'b0;
      text_on_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
      busy_q     <= busy_d;
      text_on_q  <= text_on_d;
    end
  end
  assign busy    = busy_q;
  assign text_on = text_on_q;
endmodule
